// File: rtl/bcd_display_pkg.sv
// Shared encodings for the BCD display scanner: FSM states, segment glyphs
// ({g,f,e,d,c,b,a}, active-high) and digit-enable patterns.
package bcd_display_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHOW  = 2'd1;
   localparam logic [1:0] ERROR = 2'd2;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] AN_TENS  = 2'b10;
   localparam logic [1:0] AN_UNITS = 2'b01;
   localparam logic [1:0] AN_OFF   = 2'b00;

   // Units glyph in error mode names the offending operand; both bad shows 'E'.
   function automatic logic [6:0] err_glyph(input logic [1:0] validation);
      logic [6:0] glyph;
      case (validation)
         2'b01:   glyph = SEG_1;
         2'b10:   glyph = SEG_2;
         default: glyph = SEG_E;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder; non-decimal nibbles show a dash.
module bcd_to_seg7
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Captures a 2-digit BCD product plus validation flags and scans it onto a
// multiplexed 2-digit 7-segment display, blinking an error code on bad input.
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLINK_DIV = 64,
   parameter bit          BLANK_LZ  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] res_in,
   input  logic [1:0] validation_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err,
   output logic       ready
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BW = $clog2(BLINK_DIV) + 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [7:0]    res_q, res_d;
   logic [1:0]    val_q, val_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tens_q, tens_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          ready_q, ready_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          err_q, err_d;

   logic [3:0]    nib;
   logic [6:0]    dec_seg;
   logic          wrap;

   assign wrap = (cnt_q == CNT_MAX);

   // Load wins over a coincident scan wrap: counters restart, no digit toggle.
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      tens_d  = tens_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      ready_d = ready_q;
      if (load) begin
         res_d   = res_in;
         val_d   = validation_in;
         state_d = (validation_in == 2'b00) ? SHOW : ERROR;
         cnt_d   = '0;
         tens_d  = 1'b1;
         bcnt_d  = '0;
         phase_d = 1'b1;
         ready_d = 1'b1;
      end else if (state_q != IDLE) begin
         if (wrap) begin
            cnt_d  = '0;
            tens_d = ~tens_q;
            if (bcnt_q == BLINK_MAX) begin
               bcnt_d  = '0;
               phase_d = ~phase_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign nib = tens_d ? res_d[7:4] : res_d[3:0];

   bcd_to_seg7 u_dec (
      .bcd (nib),
      .seg (dec_seg)
   );

   // Outputs are decoded from next-state values so a capture shows one cycle later.
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
      err_d = (state_d == ERROR);
      case (state_d)
         SHOW: begin
            if (!(tens_d && BLANK_LZ && (res_d[7:4] == 4'd0))) begin
               seg_d = dec_seg;
               an_d  = tens_d ? AN_TENS : AN_UNITS;
            end
         end
         ERROR: begin
            if (phase_d) begin
               seg_d = tens_d ? SEG_E : err_glyph(val_d);
               an_d  = tens_d ? AN_TENS : AN_UNITS;
            end
         end
         default: begin
            seg_d = SEG_BLANK;
            an_d  = AN_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         val_q   <= '0;
         cnt_q   <= '0;
         tens_q  <= 1'b1;
         bcnt_q  <= '0;
         phase_q <= 1'b1;
         ready_q <= 1'b0;
         seg_q   <= SEG_BLANK;
         an_q    <= AN_OFF;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         tens_q  <= tens_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         ready_q <= ready_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         err_q   <= err_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign err   = err_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with CLK_DIV=4, BLINK_DIV=2; a second
// instance with BLANK_LZ=0 covers the unblanked leading-zero case.
module tb_bcd_display_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] res_in = 8'h00;
   logic [1:0] validation_in = 2'b00;
   logic [6:0] seg, seg_n;
   logic [1:0] an, an_n;
   logic       err, err_n, ready, ready_n;

   int checks = 0;
   int errors = 0;

   logic [6:0] exp_seg;
   logic [1:0] exp_an;

   always #5 clk = ~clk;

   bcd_display_scanner #(.CLK_DIV(4), .BLINK_DIV(2), .BLANK_LZ(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .res_in        (res_in),
      .validation_in (validation_in),
      .seg           (seg),
      .an            (an),
      .err           (err),
      .ready         (ready)
   );

   bcd_display_scanner #(.CLK_DIV(4), .BLINK_DIV(2), .BLANK_LZ(1'b0)) dut_nlz (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .res_in        (res_in),
      .validation_in (validation_in),
      .seg           (seg_n),
      .an            (an_n),
      .err           (err_n),
      .ready         (ready_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1ns after the capture edge, i.e. at scan cycle 0.
   task automatic do_load(input logic [7:0] r, input logic [1:0] v);
      res_in = r;
      validation_in = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (seg !== 7'h00 || an !== 2'b00 || err !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state c=%0d: seg=%h an=%b err=%b ready=%b, required 00/00/0/0",
                     c, seg, an, err, ready);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_load(8'h36, 2'b00);
      for (int c = 0; c < 10; c++) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (seg !== 7'h00 || an !== 2'b00 || err !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: seg=%h an=%b err=%b ready=%b, required 00/00/0/0",
                  seg, an, err, ready);
      end
      #2;
      rst = 1'b0;
      tick();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (seg !== 7'h00 || an !== 2'b00 || ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset c=%0d: seg=%h an=%b ready=%b, required 00/00/0",
                     c, seg, an, ready);
         end
         tick();
      end
   endtask

   task automatic test_valid();
      do_load(8'h36, 2'b00);
      checks++;
      if (err !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL valid_flags: err=%b ready=%b, required 0/1", err, ready);
      end
      for (int c = 0; c < 16; c++) begin
         exp_an  = ((c / 4) % 2 == 0) ? 2'b10 : 2'b01;
         exp_seg = ((c / 4) % 2 == 0) ? 7'h4F : 7'h7D;
         checks++;
         if (seg !== exp_seg || an !== exp_an) begin
            errors++;
            $display("FAIL valid_36 c=%0d: seg=%h an=%b, required seg=%h an=%b",
                     c, seg, an, exp_seg, exp_an);
         end
         tick();
      end
   endtask

   task automatic test_leading_zero();
      do_load(8'h00, 2'b00);
      for (int c = 0; c < 8; c++) begin
         exp_an  = (c < 4) ? 2'b00 : 2'b01;
         exp_seg = (c < 4) ? 7'h00 : 7'h3F;
         checks++;
         if (seg !== exp_seg || an !== exp_an) begin
            errors++;
            $display("FAIL lz_blank c=%0d: seg=%h an=%b, required seg=%h an=%b",
                     c, seg, an, exp_seg, exp_an);
         end
         exp_an = (c < 4) ? 2'b10 : 2'b01;
         checks++;
         if (seg_n !== 7'h3F || an_n !== exp_an) begin
            errors++;
            $display("FAIL lz_noblank c=%0d: seg=%h an=%b, required seg=3f an=%b",
                     c, seg_n, an_n, exp_an);
         end
         tick();
      end
   endtask

   task automatic test_error_codes();
      logic [1:0] vals [3];
      logic [6:0] glyph [3];
      vals[0] = 2'b01; glyph[0] = 7'h06;
      vals[1] = 2'b10; glyph[1] = 7'h5B;
      vals[2] = 2'b11; glyph[2] = 7'h79;
      for (int k = 0; k < 3; k++) begin
         do_load(8'h36, vals[k]);
         checks++;
         if (err !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL err_flag v=%b: err=%b ready=%b, required 1/1", vals[k], err, ready);
         end
         for (int c = 0; c < 32; c++) begin
            if ((c / 8) % 2 == 1) begin
               exp_an  = 2'b00;
               exp_seg = 7'h00;
            end else if ((c / 4) % 2 == 0) begin
               exp_an  = 2'b10;
               exp_seg = 7'h79;
            end else begin
               exp_an  = 2'b01;
               exp_seg = glyph[k];
            end
            checks++;
            if (seg !== exp_seg || an !== exp_an || err !== 1'b1) begin
               errors++;
               $display("FAIL err_blink v=%b c=%0d: seg=%h an=%b err=%b, required seg=%h an=%b err=1",
                        vals[k], c, seg, an, err, exp_seg, exp_an);
            end
            tick();
         end
      end
   endtask

   task automatic test_reload_error_to_show();
      do_load(8'h36, 2'b01);
      for (int c = 0; c < 10; c++) tick();
      checks++;
      if (an !== 2'b00 || seg !== 7'h00) begin
         errors++;
         $display("FAIL blink_off_before_reload: seg=%h an=%b, required 00/00", seg, an);
      end
      do_load(8'h27, 2'b00);
      checks++;
      if (an !== 2'b10 || seg !== 7'h5B || err !== 1'b0) begin
         errors++;
         $display("FAIL reload_show: seg=%h an=%b err=%b, required seg=5b an=10 err=0",
                  seg, an, err);
      end
   endtask

   task automatic test_back_to_back();
      do_load(8'h36, 2'b00);
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (an !== 2'b10 || seg !== 7'h4F) begin
         errors++;
         $display("FAIL pre_collision: seg=%h an=%b, required seg=4f an=10", seg, an);
      end
      // Scan counter is at its terminal value here; the load must win.
      do_load(8'h45, 2'b00);
      for (int c = 0; c < 8; c++) begin
         exp_an  = (c < 4) ? 2'b10 : 2'b01;
         exp_seg = (c < 4) ? 7'h66 : 7'h6D;
         checks++;
         if (seg !== exp_seg || an !== exp_an) begin
            errors++;
            $display("FAIL collision c=%0d: seg=%h an=%b, required seg=%h an=%b",
                     c, seg, an, exp_seg, exp_an);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_valid();
      test_leading_zero();
      test_error_codes();
      test_reload_error_to_show();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the BCD multiplier. Captures its 2-digit BCD product and 2-bit validation flags on a load strobe.
- Drives a time-multiplexed 2-digit 7-segment display.
- Valid results are shown as decimal digits. Invalid inputs are shown as a blinking error code identifying the offending operand.

Parameters:
- CLK_DIV, 50000: clock cycles per digit scan slot (≥2).
- BLINK_DIV, 64: scan slots per blink half-period in error mode (≥1).
- BLANK_LZ, 1: 1 blanks the tens digit when it is 0 in valid mode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  capture strobe; sampled on rising clk.
- res_in  in  8  product; upper nibble = tens BCD digit, lower nibble = units BCD digit.
- validation_in  in  2  bit0 = first operand invalid, bit1 = second operand invalid; 00 = valid.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- an  out  2  digit enables, active-high, one-hot or 00; an[1] = tens, an[0] = units.
- err  out  1  high while in ERROR state.
- ready  out  1  high once a value has been captured since reset.

Behaviour:
- Reset (async, any time): state IDLE, seg=0, an=00, err=0, ready=0, scan counter=0, digit index=tens, blink counter=0, blink phase=on, captured registers=0.
- States:
  - IDLE: display blank, an=00.
  - SHOW: valid result.
  - ERROR: invalid input.
- Capture: load=1 at a rising edge registers res_in and validation_in. Next state is SHOW if validation_in==00, else ERROR. ready becomes 1.
- On capture, the scan counter, digit index (tens), blink counter and blink phase (on) all restart. The new value is visible on seg/an from the cycle after the capture edge (1-cycle latency).
- load is accepted in every state, including mid-scan and mid-blink. load and a scan-terminal event in the same cycle: load wins; the counter restarts, no digit toggle.
- Scan:
  - Counter counts 0..CLK_DIV-1 and wraps.
  - On the wrap cycle the digit index toggles tens↔units. Each digit is enabled for exactly CLK_DIV cycles.
  - an=10 for tens, 01 for units; seg is the decode of the selected digit.
- SHOW decode:
  - Nibble 0-9 uses the standard table.
  - Nibble >9, defensively, shows a dash (0x40).
  - Tens nibble 0 with BLANK_LZ=1: seg=0 and an=00 during the tens slot. The units slot is unchanged.
- ERROR decode:
  - Tens shows 'E' (0x79).
  - Units shows '1' (0x06) for validation 01, '2' (0x5B) for 10, 'E' for 11.
- ERROR blink: the blink counter increments on each scan wrap. When it reaches BLINK_DIV-1 and wraps, the phase toggles. During the off phase, an=00 and seg=0. Scanning continues underneath.
- err=1 exactly while in ERROR. Outputs are registered (no combinational path from inputs to seg/an).
- Segment table (hex, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - E=79, dash=40, blank=00
- Arithmetic: scan counter width = clog2(CLK_DIV); blink counter width = clog2(BLINK_DIV)+1. No overflow beyond wrap.

Decomposition:
- Package bcd_display_pkg:
  - State encoding constants IDLE/SHOW/ERROR.
  - Segment constants SEG_0..SEG_9, SEG_E, SEG_DASH, SEG_BLANK.
  - Digit-enable constants AN_TENS, AN_UNITS, AN_OFF.
- One sub-module, bcd_to_seg7: combinational 4-bit → 7-segment decoder implementing the 0-9/dash table. The top instantiates it once on the muxed nibble. The error glyphs are selected in the top.

Test Plan (CLK_DIV=4, BLINK_DIV=2):
- Reset mid-operation: load 0x36/00, run 10 cycles, assert rst asynchronously between edges → seg=00, an=00, err=0, ready=0 immediately. After release, display stays blank until the next load.
- Valid 9*4: load res_in=0x36, validation 00 → next cycle an=10, seg=4F for 4 cycles, then an=01, seg=7D for 4 cycles, repeating; err=0, ready=1.
- Leading zero 0*3: load 0x00/00 → tens slot an=00, seg=00 for 4 cycles; units slot an=01, seg=3F. With BLANK_LZ=0, the tens slot shows an=10, seg=3F.
- Error codes:
  - Load validation 01 → err=1; tens seg=79, units seg=06.
  - Load validation 10 → units seg=5B.
  - Load validation 11 → units seg=79.
  - Each case: display on for 8 cycles (2 slots), off (an=00) for 8, repeating.
- Reload and collision:
  - Reload ERROR→SHOW: during the blink-off phase, load 0x27/00 → next cycle an=10, seg=5B (tens 2), err=0.
  - Collision: load asserted on the scan-wrap cycle → counter restarts, tens slot shown, no toggle.
